// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for memory_responder: MMIO register offsets,
// CTRL bit positions and the boot-loader state encoding.
package mem_map_pkg;

    localparam logic [7:0] OFF_GPIO_IN  = 8'd0;
    localparam logic [7:0] OFF_GPIO_OUT = 8'd1;
    localparam logic [7:0] OFF_TIMER    = 8'd2;
    localparam logic [7:0] OFF_CTRL     = 8'd3;
    localparam logic [7:0] OFF_SCRATCH  = 8'd4;

    localparam int CTRL_RUN = 0;
    localparam int CTRL_OVF = 1;
    localparam int CTRL_IE  = 2;

    typedef enum logic {
        BOOT_LOAD = 1'b0,
        BOOT_RUN  = 1'b1
    } boot_state_e;

endpackage

// File: rtl/mem_timer.sv
// Prescaled 8-bit timer with sticky overflow flag, CPU load and write-1-clear,
// plus the registered interrupt output (ovf & irq-enable).
module mem_timer #(
    parameter int PRESCALE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       ld_en,
    input  logic [7:0] ld_val,
    input  logic       ovf_clr,
    input  logic       irq_en,
    output logic [7:0] count,
    output logic       ovf,
    output logic       irq
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_r, pre_nxt_s;
    logic [7:0]    count_r, count_nxt_s;
    logic          ovf_r, ovf_nxt_s, irq_r, tick_s;

    // Next-state: a CPU load beats a tick, and an overflow set beats a clear.
    always_comb begin
        pre_nxt_s   = pre_r;
        tick_s      = 1'b0;
        count_nxt_s = count_r;
        ovf_nxt_s   = ovf_r;
        if (run) begin
            if (pre_r == PRE_LAST) begin
                pre_nxt_s = '0;
                tick_s    = 1'b1;
            end else begin
                pre_nxt_s = pre_r + PW'(1);
            end
        end else begin
            pre_nxt_s = pre_r;
        end
        if (ld_en) begin
            count_nxt_s = ld_val;
        end else if (tick_s) begin
            count_nxt_s = count_r + 8'd1;
        end else begin
            count_nxt_s = count_r;
        end
        if (tick_s && !ld_en && (count_r == 8'hFF)) begin
            ovf_nxt_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r   <= '0;
            count_r <= 8'h00;
            ovf_r   <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            pre_r   <= pre_nxt_s;
            count_r <= count_nxt_s;
            ovf_r   <= ovf_nxt_s;
            irq_r   <= ovf_nxt_s & irq_en;
        end
    end

    assign count = count_r;
    assign ovf   = ovf_r;
    assign irq   = irq_r;

endmodule

// File: rtl/memory_responder.sv
// Data-bus responder: RAM below MMIO_BASE, GPIO/timer/scratch registers above.
// Define MEM_BOOTLOAD_EN to add the streaming boot loader that holds the CPU.
module memory_responder
    import mem_map_pkg::*;
#(
    parameter logic [7:0] MMIO_BASE = 8'hF0,
    parameter int         PRESCALE  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ram_write,
    input  logic [7:0] address,
    input  logic [7:0] to_ram,
    output logic [7:0] from_ram,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
`ifdef MEM_BOOTLOAD_EN
    input  logic [7:0] boot_data,
    input  logic       boot_valid,
    input  logic       boot_last,
    output logic       boot_ready,
    output logic       cpu_hold,
`endif
    output logic       timer_irq
);
    localparam int RAM_DEPTH = int'(MMIO_BASE);

    logic [7:0] ram_r [0:RAM_DEPTH-1];
    logic [7:0] gpio_s1_r, gpio_s2_r, gpio_out_r, scratch_r;
    logic       run_r, ie_r;
    logic [7:0] gpio_nxt_s, scratch_nxt_s, off_s, count_s, rd_s;
    logic [7:0] ram_waddr_s, ram_wdata_s;
    logic       run_nxt_s, ie_nxt_s, tmr_ld_s, ovf_clr_s, ovf_s;
    logic       mmio_s, cpu_we_s, sel_s, ram_we_s;

    assign mmio_s = (address >= MMIO_BASE);
    assign off_s  = address - MMIO_BASE;
    assign sel_s  = cpu_we_s & mmio_s;

`ifdef MEM_BOOTLOAD_EN
    boot_state_e state_r, state_nxt_s;
    logic [7:0]  ptr_r, ptr_nxt_s;
    logic        boot_ready_r, beat_s, booting_s;

    assign booting_s = (state_r == BOOT_LOAD);
    assign beat_s    = boot_valid & boot_ready_r;
    assign cpu_we_s  = ram_write & ~booting_s;

    // Loader FSM: a last-marked beat or the top RAM byte ends loading.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            BOOT_LOAD: begin
                if (beat_s) begin
                    ptr_nxt_s = ptr_r + 8'd1;
                    if (boot_last || (ptr_r == MMIO_BASE - 8'd1)) begin
                        state_nxt_s = BOOT_RUN;
                    end else begin
                        state_nxt_s = BOOT_LOAD;
                    end
                end else begin
                    state_nxt_s = BOOT_LOAD;
                end
            end
            BOOT_RUN: state_nxt_s = BOOT_RUN;
            default:  state_nxt_s = BOOT_LOAD;
        endcase
    end

    // Loader state registers; ready/hold are registered copies of the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= BOOT_LOAD;
            ptr_r        <= 8'd0;
            boot_ready_r <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            ptr_r        <= ptr_nxt_s;
            boot_ready_r <= (state_nxt_s == BOOT_LOAD);
        end
    end

    assign boot_ready = boot_ready_r;
    assign cpu_hold   = boot_ready_r;

    // RAM write port belongs to the loader while it is active.
    always_comb begin
        if (booting_s) begin
            ram_we_s    = beat_s;
            ram_waddr_s = ptr_r;
            ram_wdata_s = boot_data;
        end else begin
            ram_we_s    = cpu_we_s & ~mmio_s;
            ram_waddr_s = address;
            ram_wdata_s = to_ram;
        end
    end
`else
    assign cpu_we_s    = ram_write;
    assign ram_we_s    = cpu_we_s & ~mmio_s;
    assign ram_waddr_s = address;
    assign ram_wdata_s = to_ram;
`endif

    // RAM array, not reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[ram_waddr_s] <= ram_wdata_s;
        end
    end

    // MMIO register write decode.
    always_comb begin
        gpio_nxt_s    = gpio_out_r;
        scratch_nxt_s = scratch_r;
        run_nxt_s     = run_r;
        ie_nxt_s      = ie_r;
        tmr_ld_s      = 1'b0;
        ovf_clr_s     = 1'b0;
        if (sel_s) begin
            case (off_s)
                OFF_GPIO_OUT: gpio_nxt_s = to_ram;
                OFF_TIMER:    tmr_ld_s   = 1'b1;
                OFF_CTRL: begin
                    run_nxt_s = to_ram[CTRL_RUN];
                    ie_nxt_s  = to_ram[CTRL_IE];
                    ovf_clr_s = to_ram[CTRL_OVF];
                end
                OFF_SCRATCH:  scratch_nxt_s = to_ram;
                default:      tmr_ld_s      = 1'b0;
            endcase
        end else begin
            tmr_ld_s = 1'b0;
        end
    end

    // MMIO registers and the two-flop GPIO input synchroniser.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_s1_r  <= 8'h00;
            gpio_s2_r  <= 8'h00;
            gpio_out_r <= 8'h00;
            scratch_r  <= 8'h00;
            run_r      <= 1'b0;
            ie_r       <= 1'b0;
        end else begin
            gpio_s1_r  <= gpio_in;
            gpio_s2_r  <= gpio_s1_r;
            gpio_out_r <= gpio_nxt_s;
            scratch_r  <= scratch_nxt_s;
            run_r      <= run_nxt_s;
            ie_r       <= ie_nxt_s;
        end
    end

    mem_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk     (clk),
        .rst_n   (rst),
        .run     (run_r),
        .ld_en   (tmr_ld_s),
        .ld_val  (to_ram),
        .ovf_clr (ovf_clr_s),
        .irq_en  (ie_nxt_s),
        .count   (count_s),
        .ovf     (ovf_s),
        .irq     (timer_irq)
    );

    // Zero-latency read mux.
    always_comb begin
        rd_s = 8'h00;
        if (!mmio_s) begin
            rd_s = ram_r[address];
        end else begin
            case (off_s)
                OFF_GPIO_IN:  rd_s = gpio_s2_r;
                OFF_GPIO_OUT: rd_s = gpio_out_r;
                OFF_TIMER:    rd_s = count_s;
                OFF_CTRL:     rd_s = {5'd0, ie_r, ovf_s, run_r};
                OFF_SCRATCH:  rd_s = scratch_r;
                default:      rd_s = 8'h00;
            endcase
        end
    end

    assign from_ram = rd_s;
    assign gpio_out = gpio_out_r;

endmodule

// File: tb/tb_memory_responder.sv
// Directed self-checking bench for memory_responder (MMIO_BASE=F0, PRESCALE=16);
// covers the loader too when MEM_BOOTLOAD_EN is defined.
module tb_memory_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic       ram_write;
    logic [7:0] address, to_ram, from_ram, gpio_in, gpio_out;
    logic       timer_irq;
`ifdef MEM_BOOTLOAD_EN
    logic [7:0] boot_data;
    logic       boot_valid, boot_last, boot_ready, cpu_hold;
`endif
    int errors = 0;
    int checks = 0;

    memory_responder #(.MMIO_BASE(8'hF0), .PRESCALE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ram_write (ram_write),
        .address   (address),
        .to_ram    (to_ram),
        .from_ram  (from_ram),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
`ifdef MEM_BOOTLOAD_EN
        .boot_data (boot_data),
        .boot_valid(boot_valid),
        .boot_last (boot_last),
        .boot_ready(boot_ready),
        .cpu_hold  (cpu_hold),
`endif
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] e);
        address = a;
        #1;
        chk(tag, from_ram, e);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        address = a;
        to_ram = d;
        ram_write = 1'b1;
        @(posedge clk);
        #1;
        ram_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

`ifdef MEM_BOOTLOAD_EN
    task automatic beat(input logic [7:0] d, input logic last);
        boot_data = d;
        boot_valid = 1'b1;
        boot_last = last;
        @(posedge clk);
        #1;
        boot_valid = 1'b0;
        boot_last = 1'b0;
    endtask
`endif

    task automatic do_reset();
        rst = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
`ifdef MEM_BOOTLOAD_EN
        beat(8'h11, 1'b1);
`endif
    endtask

    initial begin
        rst = 1'b0;
        ram_write = 1'b0;
        address = 8'h00;
        to_ram = 8'h00;
        gpio_in = 8'h00;
`ifdef MEM_BOOTLOAD_EN
        boot_data = 8'h00;
        boot_valid = 1'b0;
        boot_last = 1'b0;
`endif
        #3;
        chk("rst_gpio_out", gpio_out, 8'h00);
        chk("rst_irq", {7'd0, timer_irq}, 8'h00);
        rd("rst_gpio_rd", 8'hF1, 8'h00);
        rd("rst_timer", 8'hF2, 8'h00);
        rd("rst_ctrl", 8'hF3, 8'h00);
        rd("rst_scratch", 8'hF4, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;

`ifdef MEM_BOOTLOAD_EN
        chk("boot_hold0", {7'd0, cpu_hold}, 8'h01);
        chk("boot_ready0", {7'd0, boot_ready}, 8'h01);
        wr(8'hF4, 8'hAA);
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        chk("boot_hold_mid", {7'd0, cpu_hold}, 8'h01);
        beat(8'h33, 1'b1);
        chk("boot_hold_done", {7'd0, cpu_hold}, 8'h00);
        chk("boot_ready_done", {7'd0, boot_ready}, 8'h00);
        rd("boot_ram0", 8'h00, 8'h11);
        rd("boot_ram1", 8'h01, 8'h22);
        rd("boot_ram2", 8'h02, 8'h33);
        rd("boot_cpu_wr_ignored", 8'hF4, 8'h00);
`endif

        // RAM and unmapped MMIO
        wr(8'h10, 8'h5A);
        rd("ram_10", 8'h10, 8'h5A);
        wr(8'hEF, 8'hC8);
        rd("ram_top", 8'hEF, 8'hC8);
        rd("ram_10_keep", 8'h10, 8'h5A);
        wr(8'hF5, 8'h77);
        rd("unmapped_f5", 8'hF5, 8'h00);
        wr(8'hF4, 8'h3C);
        rd("scratch", 8'hF4, 8'h3C);

        // GPIO synchroniser latency and output latch
        gpio_in = 8'hC3;
        rd("gpio_in_0clk", 8'hF0, 8'h00);
        idle(1);
        rd("gpio_in_1clk", 8'hF0, 8'h00);
        idle(1);
        rd("gpio_in_2clk", 8'hF0, 8'hC3);
        wr(8'hF1, 8'h81);
        chk("gpio_out", gpio_out, 8'h81);
        rd("gpio_out_rd", 8'hF1, 8'h81);

        // Overflow after 32 clocks, then write-1-clear
        do_reset();
        wr(8'hF2, 8'hFE);
        wr(8'hF3, 8'h05);
        idle(31);
        rd("t3_ctrl_31", 8'hF3, 8'h05);
        rd("t3_count_31", 8'hF2, 8'hFF);
        chk("t3_irq_31", {7'd0, timer_irq}, 8'h00);
        idle(1);
        rd("t3_ctrl_32", 8'hF3, 8'h07);
        rd("t3_count_32", 8'hF2, 8'h00);
        chk("t3_irq_32", {7'd0, timer_irq}, 8'h01);
        wr(8'hF3, 8'h02);
        chk("t3_irq_clr", {7'd0, timer_irq}, 8'h00);
        rd("t3_ctrl_clr", 8'hF3, 8'h00);

        // Load collides with the overflowing tick: load wins, no ovf
        do_reset();
        wr(8'hF2, 8'hFF);
        wr(8'hF3, 8'h05);
        idle(15);
        wr(8'hF2, 8'h40);
        rd("t4_load_wins", 8'hF2, 8'h40);
        rd("t4_no_ovf", 8'hF3, 8'h05);
        chk("t4_no_irq", {7'd0, timer_irq}, 8'h00);

        // Clear collides with overflow: set wins
        do_reset();
        wr(8'hF2, 8'hFF);
        wr(8'hF3, 8'h05);
        idle(15);
        wr(8'hF3, 8'h07);
        rd("t4_set_wins", 8'hF3, 8'h07);
        chk("t4_set_irq", {7'd0, timer_irq}, 8'h01);

        // Reset mid-count with live MMIO state
        wr(8'hF1, 8'h5A);
        wr(8'hF4, 8'h99);
        rst = 1'b0;
        #1;
        chk("t6_gpio_out", gpio_out, 8'h00);
        chk("t6_irq", {7'd0, timer_irq}, 8'h00);
        rd("t6_timer", 8'hF2, 8'h00);
        rd("t6_ctrl", 8'hF3, 8'h00);
        rd("t6_scratch", 8'hF4, 8'h00);
`ifdef MEM_BOOTLOAD_EN
        chk("t6_hold", {7'd0, cpu_hold}, 8'h01);
        chk("t6_ready", {7'd0, boot_ready}, 8'h01);
        @(posedge clk);
        #1;
        rst = 1'b1;
        beat(8'h55, 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_boot_hold", {7'd0, cpu_hold}, 8'h01);
        @(posedge clk);
        #1;
        rst = 1'b1;
        beat(8'h99, 1'b1);
        rd("t6_boot_ptr0", 8'h00, 8'h99);
        chk("t6_boot_done", {7'd0, cpu_hold}, 8'h00);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
